// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditions a raw mechanical push-button pin into a clean, glitch-free level
// for the one-pulser stage downstream. The pin is brought into the clk domain
// through a 2-flop synchroniser. A new level is only accepted after it has
// held for STABLE_CYCLES consecutive clocks. Press and release are qualified
// identically.
//
// Optional build macro:
//   DEBOUNCE_INVERT_EN - when defined, the synchroniser samples ~btn_raw so
//                        that an active-low board button reads as pressed
//                        (db_out=1) while the pin is low.
//
// Parameters:
//   STABLE_CYCLES - clocks a new level must hold before acceptance (>= 2)
//   CNT_WIDTH     - stability counter width, 2**CNT_WIDTH >= STABLE_CYCLES
//
// Ports:
//   clk     in   system clock, all state updates on posedge
//   rst     in   synchronous active-high reset
//   btn_raw in   raw button pin, asynchronous to clk, may bounce
//   db_out  out  debounced level
//   busy    out  high while a candidate level change is being qualified
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic db_out,
  output logic busy
);

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_WAIT_HIGH = 2'b01,
    S_HIGH      = 2'b10,
    S_WAIT_LOW  = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  logic                 sync1;
  logic                 sync2;
  logic                 pin_level;
  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;

`ifdef DEBOUNCE_INVERT_EN
  assign pin_level = ~btn_raw;
`else
  assign pin_level = btn_raw;
`endif

  // Synchroniser. Only sync2 is used past this point; sync1 may go metastable.
  // NOTE: every clocked register here uses non-blocking (<=) assignments so
  // that sync2 picks up the old sync1, not the value written this same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin_level;
      sync2 <= sync1;
    end
  end

  // State and counter registers; reset discards any partial qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. The counter is held at zero in the settled states and
  // restarts whenever the candidate level bounces back, so it can never pass
  // CNT_LAST.
  // NOTE: both outputs of this block get a default first so that no path
  // through the case leaves them unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = CNT_ZERO;
    case (state)
      S_LOW: begin
        if (sync2) state_nxt = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (!sync2) begin
          state_nxt = S_LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync2) state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (sync2) begin
          state_nxt = S_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_LOW;
      end
    endcase
  end

  // Outputs decode the state register only; no path from btn_raw.
  assign db_out = (state == S_HIGH) || (state == S_WAIT_LOW);
  assign busy   = (state == S_WAIT_HIGH) || (state == S_WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed self-checking bench for button_debouncer with STABLE_CYCLES=4,
// CNT_WIDTH=3. Inputs change 1 ns after a rising edge; outputs are examined
// at the same point, i.e. "after edge N". Edge 1 is the first edge that
// samples a newly driven btn_raw value. When DEBOUNCE_INVERT_EN is defined
// the inverted-pin scenario runs instead of the active-high scenarios.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int STABLE_CYCLES = 4;
  localparam int CNT_WIDTH     = 3;

  logic clk;
  logic rst;
  logic btn_raw;
  logic db_out;
  logic busy;

  int checks;
  int errors;

  // Downstream one-pulser stand-in: single-cycle enable on a db_out rise.
  logic db_q;
  logic en_pulse;
  int   pulse_cycles;

  button_debouncer #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .db_out (db_out),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign en_pulse = db_out & ~db_q;

  always @(posedge clk) begin
    db_q <= db_out;
    if (en_pulse) pulse_cycles <= pulse_cycles + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input logic idle_level);
    rst     = 1'b1;
    btn_raw = idle_level;
    step();
    step();
    checks++;
    if (db_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_db_out: got %b expected 0", db_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (dut.cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", dut.cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    logic exp_busy;
    logic exp_db;
    btn_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_busy = (e >= 3 && e <= 6);
      exp_db   = (e >= 7);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL clean_press_busy edge %0d: got %b expected %b", e, busy, exp_busy);
      end
      checks++;
      if (db_out !== exp_db) begin
        errors++;
        $display("FAIL clean_press_db_out edge %0d: got %b expected %b", e, db_out, exp_db);
      end
    end
  endtask

  // Starts in S_HIGH, leaves the design in S_LOW.
  task automatic test_glitch();
    logic exp_db;
    btn_raw = 1'b0;
    step();
    btn_raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (db_out !== 1'b1) begin
        errors++;
        $display("FAIL glitch_1cyc_db_out step %0d: got %b expected 1", e, db_out);
      end
    end
    btn_raw = 1'b0;
    for (int e = 1; e <= 3; e++) step();
    btn_raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (db_out !== 1'b1) begin
        errors++;
        $display("FAIL glitch_3cyc_db_out step %0d: got %b expected 1", e, db_out);
      end
    end
    btn_raw = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_db = (e < 7);
      checks++;
      if (db_out !== exp_db) begin
        errors++;
        $display("FAIL release_db_out edge %0d: got %b expected %b", e, db_out, exp_db);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL release_busy: got %b expected 0", busy);
    end
  endtask

  // Starts in S_LOW, leaves the design in S_LOW.
  task automatic test_bounce();
    logic pattern [4];
    logic exp_db;
    pattern[0] = 1'b1;
    pattern[1] = 1'b0;
    pattern[2] = 1'b1;
    pattern[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn_raw = pattern[i];
      step();
      checks++;
      if (db_out !== 1'b0) begin
        errors++;
        $display("FAIL bounce_db_out step %0d: got %b expected 0", i, db_out);
      end
    end
    btn_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_db = (e >= 7);
      checks++;
      if (db_out !== exp_db) begin
        errors++;
        $display("FAIL bounce_settle_db_out edge %0d: got %b expected %b", e, db_out, exp_db);
      end
    end
    btn_raw = 1'b0;
    for (int e = 1; e <= 8; e++) step();
    checks++;
    if (db_out !== 1'b0) begin
      errors++;
      $display("FAIL bounce_release_db_out: got %b expected 0", db_out);
    end
  endtask

  // Starts in S_LOW, leaves the design in S_LOW.
  task automatic test_reset_mid();
    logic exp_db;
    btn_raw = 1'b1;
    for (int e = 1; e <= 5; e++) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midq_busy_before: got %b expected 1", busy);
    end
    checks++;
    if (dut.cnt !== 3'd2) begin
      errors++;
      $display("FAIL midq_cnt_before: got %0d expected 2", dut.cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midq_busy_after_rst: got %b expected 0", busy);
    end
    checks++;
    if (db_out !== 1'b0) begin
      errors++;
      $display("FAIL midq_db_out_after_rst: got %b expected 0", db_out);
    end
    checks++;
    if (dut.cnt !== 3'd0) begin
      errors++;
      $display("FAIL midq_cnt_after_rst: got %0d expected 0", dut.cnt);
    end
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_db = (e >= 7);
      checks++;
      if (db_out !== exp_db) begin
        errors++;
        $display("FAIL midq_requal_db_out edge %0d: got %b expected %b", e, db_out, exp_db);
      end
    end
    btn_raw = 1'b0;
    for (int e = 1; e <= 8; e++) step();
  endtask

  // Press with three bounces, hold, release: exactly one enable pulse.
  task automatic test_back_to_back_integration();
    int start_cycles;
    start_cycles = pulse_cycles;
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'b1;
      step();
      btn_raw = 1'b0;
      step();
    end
    btn_raw = 1'b1;
    for (int e = 1; e <= 10; e++) step();
    btn_raw = 1'b0;
    for (int e = 1; e <= 10; e++) step();
    checks++;
    if (pulse_cycles - start_cycles !== 1) begin
      errors++;
      $display("FAIL integration_pulse_cycles: got %0d expected 1", pulse_cycles - start_cycles);
    end
    checks++;
    if (db_out !== 1'b0) begin
      errors++;
      $display("FAIL integration_final_db_out: got %b expected 0", db_out);
    end
  endtask

  task automatic test_invert();
    logic exp_db;
    btn_raw = 1'b1;
    for (int e = 1; e <= 10; e++) step();
    checks++;
    if (db_out !== 1'b0) begin
      errors++;
      $display("FAIL invert_idle_db_out: got %b expected 0", db_out);
    end
    btn_raw = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_db = (e >= 7);
      checks++;
      if (db_out !== exp_db) begin
        errors++;
        $display("FAIL invert_press_db_out edge %0d: got %b expected %b", e, db_out, exp_db);
      end
    end
    btn_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_db = (e < 7);
      checks++;
      if (db_out !== exp_db) begin
        errors++;
        $display("FAIL invert_release_db_out edge %0d: got %b expected %b", e, db_out, exp_db);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    pulse_cycles = 0;
    db_q         = 1'b0;
    rst          = 1'b1;
    btn_raw      = 1'b0;
`ifdef DEBOUNCE_INVERT_EN
    test_reset(1'b1);
    test_invert();
`else
    test_reset(1'b0);
    test_clean_press();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_back_to_back_integration();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw mechanical push-button input into a clean, glitch-free level that drives the pushbutton input of the one-pulser stage directly downstream.
- Synchronises the asynchronous pin into the clk domain with a 2-flop synchroniser.
- Accepts a level change only after it has held for STABLE_CYCLES consecutive clocks.
- Sits between the board button pin and the single-pulse generator in every lab top level.

Parameters:
- STABLE_CYCLES, 500000, consecutive clk cycles a new level must hold before it is accepted (10 ms at 50 MHz); legal range >= 2.
- CNT_WIDTH, 20, stability counter width; must satisfy 2**CNT_WIDTH >= STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- btn_raw  input  1  raw button pin; asynchronous to clk, may bounce.
- db_out  output  1  debounced level; feeds the one-pulser pushbutton input.
- busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Synchroniser: sync1 <= btn_raw, sync2 <= sync1. Only sync2 is used downstream of the synchroniser.
- State register: 2 bits, states S_LOW=00, S_WAIT_HIGH=01, S_HIGH=10, S_WAIT_LOW=11. Any illegal or default encoding goes to S_LOW next edge.
- Counter cnt [CNT_WIDTH-1:0].
- Reset (rst=1 at a posedge):
  - sync1=sync2=0, state=S_LOW, cnt=0.
  - Outputs are 0 after that edge.
  - Reset mid-qualification discards the candidate; no partial count survives.
- Transitions, evaluated every posedge with rst=0:
  - S_LOW: sync2=1 -> S_WAIT_HIGH, cnt=0; else stay, cnt=0.
  - S_WAIT_HIGH:
    - sync2=0 -> S_LOW, cnt=0 (bounce rejected).
    - sync2=1 and cnt==STABLE_CYCLES-1 -> S_HIGH, cnt=0.
    - Otherwise cnt=cnt+1.
  - S_HIGH: sync2=0 -> S_WAIT_LOW, cnt=0; else stay, cnt=0.
  - S_WAIT_LOW:
    - sync2=1 -> S_HIGH, cnt=0.
    - sync2=0 and cnt==STABLE_CYCLES-1 -> S_LOW, cnt=0.
    - Otherwise cnt=cnt+1.
- Outputs are a pure decode of the state register, with no combinational path from btn_raw:
  - db_out = 1 in S_HIGH and S_WAIT_LOW, else 0.
  - busy = 1 in S_WAIT_HIGH and S_WAIT_LOW.
- Latency: if btn_raw is first sampled high at edge 1 and held, db_out rises after edge STABLE_CYCLES+3. Falling edge latency is identical.
- Qualification is symmetric: press and release use the same STABLE_CYCLES.
- cnt never exceeds STABLE_CYCLES-1, so no counter wrap is possible.
- A single-cycle glitch on btn_raw never changes db_out.
- Any bounce during qualification restarts qualification from zero on the next qualifying edge.
- rst has priority over every transition.

Optional Feature:
- Macro: DEBOUNCE_INVERT_EN.
- Defined: the first synchroniser flop samples ~btn_raw, for active-low board buttons. db_out=1 means "button pressed" (pin low).
  - On reset, sync1 and sync2 still clear to 0, so the first qualified press needs a pin-low hold of STABLE_CYCLES.
- Undefined: btn_raw is sampled as-is (active-high button).
- Ports, parameters, states and latency are identical in both builds.

Test Plan (STABLE_CYCLES=4, CNT_WIDTH=3, macro undefined unless stated):
- Clean press: rst for 2 cycles, then btn_raw=1 held from edge 1 -> busy=1 after edge 3, db_out=0 through edge 6, db_out=1 and busy=0 after edge 7.
- Bounce on press: btn_raw 1,0,1,0 on successive edges, then held 1 -> db_out stays 0 throughout the bounce; db_out=1 exactly 7 edges after the final 0->1 sample.
- Glitch rejection: from S_HIGH, drive btn_raw=0 for 1 cycle and for 3 cycles -> db_out stays 1 in both cases. A 4-cycle-plus low hold then gives db_out=0 after the 7th edge.
- Reset mid-operation: assert rst for one edge while in S_WAIT_HIGH with cnt=2 -> state=S_LOW, cnt=0, db_out=0, busy=0 after that edge. After release with btn_raw still 1, a full 7-edge qualification is required again.
- Downstream integration: connect db_out to the one-pulser pushbutton input and press once with 3 bounces -> exactly one single-cycle enable pulse.
- DEBOUNCE_INVERT_EN defined: btn_raw held 1 -> db_out=0. btn_raw driven 0 and held -> db_out=1 after edge 7. btn_raw back to 1 -> db_out=0 after a further 7 edges.
